// File: rtl/seq6_monitor.sv
// Phase tracker and self-check for the six-state sequence counter output.
// Hunts for S0, verifies LOCK_LEN correct steps, then flywheels through isolated misses.
module seq6_monitor #(
  parameter logic [2:0] S0 = 3'd0,
  parameter logic [2:0] S1 = 3'd1,
  parameter logic [2:0] S2 = 3'd3,
  parameter logic [2:0] S3 = 3'd7,
  parameter logic [2:0] S4 = 3'd6,
  parameter logic [2:0] S5 = 3'd4,
  parameter int unsigned LOCK_LEN   = 6,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       count_valid,
  input  logic [2:0] count,
  output logic [2:0] phase,
  output logic       locked,
  output logic       wrap_pulse,
  output logic       err_pulse,
  output logic       illegal,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [3:0] LOCK_LEN_C   = LOCK_LEN[3:0];
  localparam logic [2:0] MISS_LIMIT_C = MISS_LIMIT[2:0];

  state_t     state, state_n;
  logic [2:0] phase_n;
  logic       locked_n, wrap_n, err_n, illegal_n;
  logic [7:0] err_count_n;
  logic [3:0] match_cnt, match_cnt_n, match_inc;
  logic [2:0] miss_cnt, miss_cnt_n, miss_inc;
  logic [2:0] next_phase, expected;
  logic       is_legal;

  function automatic logic [2:0] code_at(input logic [2:0] p);
    logic [2:0] c;
    case (p)
      3'd0:    c = S0;
      3'd1:    c = S1;
      3'd2:    c = S2;
      3'd3:    c = S3;
      3'd4:    c = S4;
      3'd5:    c = S5;
      default: c = S0;
    endcase
    return c;
  endfunction

  assign next_phase = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
  assign expected   = code_at(next_phase);
  assign is_legal   = (count == S0) || (count == S1) || (count == S2) ||
                      (count == S3) || (count == S4) || (count == S5);
  assign match_inc  = match_cnt + 4'd1;
  assign miss_inc   = miss_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (rstb) begin
      state      <= HUNT;
      phase      <= 3'd0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      illegal    <= 1'b0;
      err_count  <= 8'd0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 3'd0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      locked     <= locked_n;
      wrap_pulse <= wrap_n;
      err_pulse  <= err_n;
      illegal    <= illegal_n;
      err_count  <= err_count_n;
      match_cnt  <= match_cnt_n;
      miss_cnt   <= miss_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    locked_n    = locked;
    wrap_n      = 1'b0;
    err_n       = 1'b0;
    illegal_n   = 1'b0;
    err_count_n = err_count;
    match_cnt_n = match_cnt;
    miss_cnt_n  = miss_cnt;

    if (count_valid) begin
      illegal_n = !is_legal;
      case (state)
        HUNT: begin
          if (count == S0) begin
            phase_n     = 3'd0;
            match_cnt_n = 4'd0;
            state_n     = SYNC;
          end
        end
        SYNC: begin
          if (count == expected) begin
            phase_n     = next_phase;
            match_cnt_n = match_inc;
            if (match_inc == LOCK_LEN_C) begin
              state_n    = LOCKED;
              locked_n   = 1'b1;
              miss_cnt_n = 3'd0;
            end
          end else if (count == S0) begin
            phase_n     = 3'd0;
            match_cnt_n = 4'd0;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          if (count == expected) begin
            phase_n    = next_phase;
            miss_cnt_n = 3'd0;
            wrap_n     = (next_phase == 3'd0);
          end else begin
            // Flywheel: keep stepping the phase so a lone glitch does not desync us.
            err_n       = 1'b1;
            err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            if (miss_inc == MISS_LIMIT_C) begin
              state_n    = HUNT;
              locked_n   = 1'b0;
              phase_n    = 3'd0;
              miss_cnt_n = 3'd0;
            end else begin
              miss_cnt_n = miss_inc;
              phase_n    = next_phase;
            end
          end
        end
        default: begin
          state_n  = HUNT;
          locked_n = 1'b0;
          phase_n  = 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq6_monitor.sv
// Directed bench for seq6_monitor: lock, wrap, glitch, loss, gating, reset, saturation.
// A second instance with MISS_LIMIT = 7 shares the stimulus for the saturation run.
module tb_seq6_monitor;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       count_valid = 1'b0;
  logic [2:0] count = 3'd0;

  logic [2:0] phase, phase7;
  logic       locked, locked7;
  logic       wrap_pulse, wrap_pulse7;
  logic       err_pulse, err_pulse7;
  logic       illegal, illegal7;
  logic [7:0] err_count, err_count7;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  seq6_monitor dut (
    .clk(clk), .rstb(rstb), .count_valid(count_valid), .count(count),
    .phase(phase), .locked(locked), .wrap_pulse(wrap_pulse),
    .err_pulse(err_pulse), .illegal(illegal), .err_count(err_count)
  );

  seq6_monitor #(.MISS_LIMIT(7)) dut7 (
    .clk(clk), .rstb(rstb), .count_valid(count_valid), .count(count),
    .phase(phase7), .locked(locked7), .wrap_pulse(wrap_pulse7),
    .err_pulse(err_pulse7), .illegal(illegal7), .err_count(err_count7)
  );

  task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] c);
    @(negedge clk);
    rstb        = rst;
    count_valid = v;
    count       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [2:0] e_phase, input logic e_locked,
                            input logic e_wrap, input logic e_err, input logic e_ill,
                            input logic [7:0] e_cnt);
    checkOutput({tag, ".phase"}, {5'd0, phase}, {5'd0, e_phase});
    checkOutput({tag, ".locked"}, {7'd0, locked}, {7'd0, e_locked});
    checkOutput({tag, ".wrap"}, {7'd0, wrap_pulse}, {7'd0, e_wrap});
    checkOutput({tag, ".err"}, {7'd0, err_pulse}, {7'd0, e_err});
    checkOutput({tag, ".illegal"}, {7'd0, illegal}, {7'd0, e_ill});
    checkOutput({tag, ".err_count"}, err_count, e_cnt);
  endtask

  logic [2:0] seq [7] = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0};
  logic [2:0] seq_ph [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
  logic [2:0] garbage [5] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd1};

  initial begin
    int wraps;
    int exp_sat;
    wraps = 0;

    applyStimulus(1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 3'd0);
    checkState("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, seq[i]);
      checkState($sformatf("lock%0d", i), seq_ph[i], (i == 6), 1'b0, 1'b0, 1'b0, 8'd0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [2:0] ep;
      ep = 3'((i + 1) % 6);
      applyStimulus(1'b0, 1'b1, seq[(i % 6) + 1]);
      wraps += int'(wrap_pulse);
      checkState($sformatf("wrap%0d", i), ep, 1'b1, (ep == 3'd0), 1'b0, 1'b0, 8'd0);
    end
    checkOutput("wrap_total", 8'(wraps), 8'd2);

    applyStimulus(1'b0, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b1, 3'd3);
    applyStimulus(1'b0, 1'b1, 3'd7);
    checkState("pre_glitch", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 3'd5);
    checkState("glitch", 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    applyStimulus(1'b0, 1'b1, 3'd4);
    checkState("glitch_recover", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b1, 3'd0);
    checkState("wrap_after_glitch", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b1, 3'd1);
    checkState("pre_loss", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

    // First miss only survives if the glitch recovery really cleared the miss counter
    applyStimulus(1'b0, 1'b1, 3'd0);
    checkState("miss1", 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    applyStimulus(1'b0, 1'b1, 3'd0);
    checkState("miss2", 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);

    applyStimulus(1'b0, 1'b1, 3'd5);
    checkState("hunt_illegal", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);

    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, seq[i]);
    checkState("relock", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    applyStimulus(1'b0, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b1, 3'd3);
    checkState("relock_run", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, garbage[i]);
      checkState($sformatf("gated%0d", i), 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    end

    applyStimulus(1'b1, 1'b1, 3'd7);
    checkState("midrun_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("midrun_reset.err_count7", err_count7, 8'd0);

    for (int b = 0; b < 43; b++) begin
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, seq[i]);
      checkOutput($sformatf("sat%0d.locked7", b), {7'd0, locked7}, 8'd1);
      for (int k = 1; k <= 7; k++) begin
        applyStimulus(1'b0, 1'b1, 3'd2);
        if (k == 6) checkOutput($sformatf("sat%0d.hold7", b), {7'd0, locked7}, 8'd1);
      end
      exp_sat = (7 * (b + 1) > 255) ? 255 : 7 * (b + 1);
      checkOutput($sformatf("sat%0d.drop7", b), {7'd0, locked7}, 8'd0);
      checkOutput($sformatf("sat%0d.err_count7", b), err_count7, 8'(exp_sat));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/seq6_monitor.md
Name: seq6_monitor

Overview:
- Downstream consumer of the six-state sequence counter's 3-bit `count` output.
- Checks that `count` follows the expected six-state cycle and tracks which phase (0..5) the counter is in.
- Declares lock after a run of correct transitions and flags mismatches and illegal codes.
- Counts errors with saturation; used as the self-check and phase-decode stage behind the counter.

Parameters:
- S0, 3'd0: expected code at phase 0
- S1, 3'd1: expected code at phase 1
- S2, 3'd3: expected code at phase 2
- S3, 3'd7: expected code at phase 3
- S4, 3'd6: expected code at phase 4
- S5, 3'd4: expected code at phase 5
- LOCK_LEN, 6: consecutive correct transitions required to enter LOCKED (range 1..15)
- MISS_LIMIT, 2: consecutive mismatches in LOCKED that drop back to HUNT (range 1..7)

Ports:
- clk, input, 1: clock; all state updates on the rising edge
- rstb, input, 1: reset; synchronous and active-high
- count_valid, input, 1: `count` is meaningful this cycle; low freezes all state
- count, input, 3: code from the sequence counter
- phase, output, 3: current phase index 0..5 (registered)
- locked, output, 1: monitor is in LOCKED
- wrap_pulse, output, 1: one-cycle pulse on a phase 5 -> 0 transition while LOCKED
- err_pulse, output, 1: one-cycle pulse on a mismatch while LOCKED
- illegal, output, 1: one-cycle pulse when a valid `count` matches none of S0..S5
- err_count, output, 8: number of mismatches in LOCKED, saturates at 255

Behaviour:
- Reset (rstb = 1 at a rising edge):
  - state goes to HUNT; phase = 0; locked = 0; all pulses = 0; err_count = 0.
  - Internal match and miss counters clear.
  - Reset has priority over every other input; a reset mid-operation takes effect on that edge.
- Timing: all outputs are registered, so the response to a sample appears one cycle after the edge where that sample is taken.
- Pulse outputs default to 0 every cycle and are high only in the cycle following the triggering sample.
- count_valid = 0: no state, phase or counter changes; all pulses are 0 that cycle.
- Expected next code: E = S[(phase + 1) mod 6]. The phase increment wraps 5 -> 0.
- illegal: asserted in any state when count_valid = 1 and `count` is not in {S0..S5}. It is independent of, and may coincide with, err_pulse.
- HUNT:
  - count == S0: phase <= 0, match counter <= 0, go to SYNC.
  - Otherwise stay in HUNT.
- SYNC:
  - count == E: phase advances, match counter increments.
  - When the incremented match counter equals LOCK_LEN: go to LOCKED, locked <= 1, miss counter <= 0.
  - count != E and count == S0: restart; phase <= 0, match counter <= 0, stay in SYNC.
  - count != E and count != S0: go to HUNT.
- LOCKED:
  - count == E: phase advances, miss counter <= 0. A 5 -> 0 advance raises wrap_pulse.
  - count != E (flywheel): phase still advances to the expected position; err_pulse = 1; err_count increments (saturating); miss counter increments. wrap_pulse is not raised on a mismatch cycle.
  - When the miss counter reaches MISS_LIMIT: go to HUNT, locked <= 0, phase <= 0.
  - A match between mismatches resets the miss counter.
- err_count: 8-bit unsigned; holds at 255 with no wrap. It is cleared only by reset.
- Sequence order is defined only by the parameters. S0..S5 must be distinct; duplicate values are unsupported.

Test Plan:
- Reset then lock:
  - Stimulus: rstb high for 2 cycles, then the valid stream 0,1,3,7,6,4,0.
  - Required: locked rises 1 cycle after the 7th sample (6th correct transition); phase shows 0 and locked stays 1.
- Wrap and phase decode:
  - Stimulus: once LOCKED, 12 more correct samples.
  - Required: phase steps 1,3,... as indices 1,2,3,4,5,0 repeating; wrap_pulse is high exactly 2 times, each on phase returning to 0.
- Single glitch tolerance:
  - Stimulus: in LOCKED, inject count = 5 in place of 6.
  - Required: illegal = 1 and err_pulse = 1 for one cycle; err_count = 1; phase still advances to 4; locked stays 1; the next correct sample clears the miss counter.
- Loss of lock:
  - Stimulus: in LOCKED, two consecutive wrong legal codes (expected 3, give 0 then 0).
  - Required: err_count += 2; locked = 0 and phase = 0 one cycle after the second mismatch; state is HUNT.
- Valid gating and mid-run reset:
  - Stimulus: count_valid low for 5 cycles with garbage on `count`.
  - Required: phase and locked unchanged; no pulses.
  - Stimulus: then rstb for 1 cycle while LOCKED.
  - Required: next cycle locked = 0, phase = 0, err_count = 0.
- Saturation:
  - Stimulus: force 300 mismatches with MISS_LIMIT overridden to 7, re-locking between bursts.
  - Required: err_count stops at 255 and stays there.
